// File: rtl/pwr_cntr_pkg.sv
// Shared definitions for the transition-counter bank.
//   CNT_W   : width of every activity counter
//   CNT_SAT : value a counter sticks at once it overflows
//   estado_t: host-side FSM states (IDLE, DUMP)
package pwr_cntr_pkg;
  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } estado_t;
endpackage

// File: rtl/popcount_sat_add.sv
// Per-channel toggle accumulator: counts the bits that differ between the
// current and previous probe sample and adds that to the running count,
// clamping at CNT_SAT instead of wrapping.
//   actual : current probe sample
//   previo : previous probe sample (history)
//   cuenta : current counter value
//   suma   : saturated cuenta + popcount(actual ^ previo)
module popcount_sat_add
  import pwr_cntr_pkg::*;
#(
  parameter int PROBE_W = 8
) (
  input  logic [PROBE_W-1:0] actual,
  input  logic [PROBE_W-1:0] previo,
  input  logic [CNT_W-1:0]   cuenta,
  output logic [CNT_W-1:0]   suma
);
  localparam int PC_W = $clog2(PROBE_W + 1);

  logic [PC_W-1:0]  pc;
  logic [CNT_W:0]   ext;

  always_comb begin
    pc = '0;
    for (int b = 0; b < PROBE_W; b++) pc = pc + PC_W'(actual[b] ^ previo[b]);
    // one spare MSB catches the carry that signals overflow
    ext  = {1'b0, cuenta} + (CNT_W + 1)'(pc);
    suma = ext[CNT_W] ? CNT_SAT : ext[CNT_W-1:0];
  end
endmodule

// File: rtl/contador_transiciones_sinc.sv
// Synchronous transition-counter bank. Watches NUM_CNTR probe buses and
// keeps a saturating 32-bit bit-toggle count per channel. The host reads
// (LE=1) or writes (LE=0, wr=1) counters by address, or streams all of
// them out with a one-cycle volcar request.
//   clk, reset          : clock, synchronous active-high reset
//   habilitar           : counting enable
//   sondas              : probe buses, channel i = [i*PROBE_W +: PROBE_W]
//   dir, LE, wr, dato_in: host address / read-not-write / write strobe / data
//   volcar              : dump request
//   dato_out, dato_valido, ultimo, ocupado : registered read/dump response
module contador_transiciones_sinc
  import pwr_cntr_pkg::*;
#(
  parameter int NUM_CNTR = 3,
  parameter int NDIR     = 2,
  parameter int PROBE_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        habilitar,
  input  logic [NUM_CNTR*PROBE_W-1:0] sondas,
  input  logic [NDIR-1:0]             dir,
  input  logic                        LE,
  input  logic                        wr,
  input  logic [CNT_W-1:0]            dato_in,
  input  logic                        volcar,
  output logic [CNT_W-1:0]            dato_out,
  output logic                        dato_valido,
  output logic                        ultimo,
  output logic                        ocupado
);
  logic [NUM_CNTR-1:0][CNT_W-1:0] cnt, cnt_inc;
  logic [NUM_CNTR*PROBE_W-1:0]    hist;
  logic                           primado;
  logic [NUM_CNTR-1:0]            wr_hit;
  logic [CNT_W-1:0]               rd_val, dump_val;
  logic [NDIR-1:0]                idx;
  estado_t                        estado;

  for (genvar g = 0; g < NUM_CNTR; g++) begin : g_ch
    popcount_sat_add #(.PROBE_W(PROBE_W)) u_ch (
      .actual (sondas[g*PROBE_W +: PROBE_W]),
      .previo (hist[g*PROBE_W +: PROBE_W]),
      .cuenta (cnt[g]),
      .suma   (cnt_inc[g])
    );
  end

  // Address decode by comparison so out-of-range dir simply matches nothing
  // (reads return 0, writes are dropped).
  always_comb begin
    rd_val   = '0;
    dump_val = '0;
    wr_hit   = '0;
    for (int i = 0; i < NUM_CNTR; i++) begin
      if (dir == NDIR'(i)) rd_val   = cnt[i];
      if (idx == NDIR'(i)) dump_val = cnt[i];
      wr_hit[i] = !LE && wr && (dir == NDIR'(i));
    end
  end

  // Counters and history. The first enabled edge after reset only loads the
  // history so the arbitrary initial probe value is not counted as toggles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      hist    <= '0;
      primado <= 1'b0;
    end else begin
      if (habilitar) begin
        hist    <= sondas;
        primado <= 1'b1;
      end
      for (int i = 0; i < NUM_CNTR; i++) begin
        if (wr_hit[i])                 cnt[i] <= dato_in;
        else if (habilitar && primado) cnt[i] <= cnt_inc[i];
      end
    end
  end

  // Host response FSM. Word 0 is issued on the edge that accepts volcar so
  // the dump data starts one cycle after the request; idx then points at
  // the next word to send and is parked at 0 while IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= IDLE;
      idx         <= '0;
      dato_out    <= '0;
      dato_valido <= 1'b0;
      ultimo      <= 1'b0;
      ocupado     <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          ultimo <= 1'b0;
          if (volcar) begin
            estado      <= DUMP;
            ocupado     <= 1'b1;
            dato_out    <= dump_val;
            dato_valido <= 1'b1;
            ultimo      <= (NUM_CNTR == 1);
            idx         <= NDIR'(1);
          end else if (LE) begin
            dato_out    <= rd_val;
            dato_valido <= 1'b1;
          end else begin
            dato_valido <= 1'b0;
          end
        end
        DUMP: begin
          if (ultimo) begin
            // last word already out: release ocupado one cycle after ultimo
            estado      <= IDLE;
            ocupado     <= 1'b0;
            dato_valido <= 1'b0;
            ultimo      <= 1'b0;
            idx         <= '0;
          end else begin
            dato_out    <= dump_val;
            dato_valido <= 1'b1;
            ultimo      <= (idx == NDIR'(NUM_CNTR - 1));
            idx         <= idx + 1'b1;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_contador_transiciones_sinc.sv
module tb_contador_transiciones_sinc;
  localparam int NUM_CNTR = 3;
  localparam int NDIR     = 2;
  localparam int PROBE_W  = 8;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        habilitar;
  logic [NUM_CNTR*PROBE_W-1:0] sondas;
  logic [NDIR-1:0]             dir;
  logic                        LE;
  logic                        wr;
  logic [31:0]                 dato_in;
  logic                        volcar;
  logic [31:0]                 dato_out;
  logic                        dato_valido;
  logic                        ultimo;
  logic                        ocupado;

  always #5 clk = ~clk;

  contador_transiciones_sinc #(.NUM_CNTR(NUM_CNTR), .NDIR(NDIR), .PROBE_W(PROBE_W)) dut (
    .clk(clk), .reset(reset), .habilitar(habilitar), .sondas(sondas), .dir(dir),
    .LE(LE), .wr(wr), .dato_in(dato_in), .volcar(volcar), .dato_out(dato_out),
    .dato_valido(dato_valido), .ultimo(ultimo), .ocupado(ocupado)
  );

  typedef struct {
    logic [31:0] dato;
    logic        ult;
  } ent_t;

  ent_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic u);
    ent_t e;
    e.dato = d;
    e.ult  = u;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare the response against the scoreboard.
  task automatic tick(input string tag);
    ent_t e;
    @(posedge clk);
    #1;
    chk({tag, "_valido"}, 32'(dato_valido), 32'(sb.size() != 0));
    if (dato_valido && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_dato"}, dato_out, e.dato);
      chk({tag, "_ultimo"}, 32'(ultimo), 32'(e.ult));
    end else begin
      chk({tag, "_ultimo0"}, 32'(ultimo), 32'd0);
    end
  endtask

  task automatic rd(input logic [NDIR-1:0] a, input logic [31:0] exp, input string tag);
    LE  = 1'b1;
    dir = a;
    push(exp, 1'b0);
    tick(tag);
    LE  = 1'b0;
  endtask

  task automatic wrt(input logic [NDIR-1:0] a, input logic [31:0] d, input string tag);
    LE      = 1'b0;
    wr      = 1'b1;
    dir     = a;
    dato_in = d;
    tick(tag);
    wr      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; habilitar = 1'b0; sondas = '0; dir = '0;
    LE = 1'b0; wr = 1'b0; dato_in = '0; volcar = 1'b0;
    tick("rst0");
    tick("rst1");
    chk("rst_dato_out", dato_out, 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    reset = 1'b0;

    // priming then 00->FF->00 on channel 0
    habilitar = 1'b1;
    sondas[0 +: 8] = 8'h00; tick("prime");
    sondas[0 +: 8] = 8'hFF; tick("tog1");
    sondas[0 +: 8] = 8'h00; tick("tog2");
    habilitar = 1'b0;
    rd(2'd0, 32'd16, "rd_ch0");
    rd(2'd1, 32'd0,  "rd_ch1");
    rd(2'd2, 32'd0,  "rd_ch2");
    tick("idle1");

    // saturation: write wins on the first edge, then toggles clamp
    habilitar = 1'b1;
    sondas[8 +: 8] = 8'hFF;
    wrt(2'd1, 32'hFFFF_FFF0, "wr_sat");
    LE = 1'b1; dir = 2'd1;
    sondas[8 +: 8] = 8'h00; push(32'hFFFF_FFF0, 1'b0); tick("sat0");
    sondas[8 +: 8] = 8'hFF; push(32'hFFFF_FFF8, 1'b0); tick("sat1");
    sondas[8 +: 8] = 8'h00; push(32'hFFFF_FFFF, 1'b0); tick("sat2");
    sondas[8 +: 8] = 8'hFF; push(32'hFFFF_FFFF, 1'b0); tick("sat3");
    LE = 1'b0;
    habilitar = 1'b0;
    rd(2'd1, 32'hFFFF_FFFF, "rd_sat_hold");

    // write vs. same-cycle increment on channel 2; channel 0 still counts
    habilitar = 1'b1;
    sondas[16 +: 8] = 8'h07;
    sondas[0 +: 8]  = 8'h01;
    wrt(2'd2, 32'd5, "wr_conflict");
    habilitar = 1'b0;
    rd(2'd2, 32'd5,  "rd_wr_wins");
    rd(2'd0, 32'd17, "rd_ch0_inc");

    // out-of-range address
    rd(2'd3, 32'd0, "rd_oob");
    wrt(2'd3, 32'hDEAD_BEEF, "wr_oob");
    rd(2'd0, 32'd17,         "rd_oob_c0");
    rd(2'd1, 32'hFFFF_FFFF,  "rd_oob_c1");
    rd(2'd2, 32'd5,          "rd_oob_c2");

    // dump 7/8/9; read + volcar in the same cycle -> dump wins
    wrt(2'd0, 32'd7, "pre0");
    wrt(2'd1, 32'd8, "pre1");
    wrt(2'd2, 32'd9, "pre2");
    volcar = 1'b1; LE = 1'b1; dir = 2'd1;
    push(32'd7, 1'b0); push(32'd8, 1'b0); push(32'd9, 1'b1);
    tick("dump0");
    chk("dump0_ocupado", 32'(ocupado), 32'd1);
    tick("dump1");                      // volcar + read held: ignored
    chk("dump1_ocupado", 32'(ocupado), 32'd1);
    volcar = 1'b0; LE = 1'b0;
    tick("dump2");
    chk("dump2_ocupado", 32'(ocupado), 32'd1);
    tick("dump_end");
    chk("dump_end_ocupado", 32'(ocupado), 32'd0);

    // reset on the second dump cycle
    volcar = 1'b1;
    push(32'd7, 1'b0);
    tick("rdump0");
    volcar = 1'b0;
    sb.delete();
    reset = 1'b1;
    tick("rdump_rst");
    chk("rdump_ocupado", 32'(ocupado), 32'd0);
    chk("rdump_dato_out", dato_out, 32'd0);
    reset = 1'b0;
    volcar = 1'b1;
    push(32'd0, 1'b0); push(32'd0, 1'b0); push(32'd0, 1'b1);
    tick("zdump0");
    volcar = 1'b0;
    tick("zdump1");
    tick("zdump2");
    tick("zdump_end");
    chk("zdump_ocupado", 32'(ocupado), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/contador_transiciones_sinc.md
# contador_transiciones_sinc

Synchronous transition-counter bank: the hardware responder for the `dir`/`LE` counter-memory protocol that our power-analysis benches use as initiator. It lets a synthesized adder netlist measure its own switching activity. The block watches `NUM_CNTR` probe buses and accumulates per-channel bit-toggle counts in saturating 32-bit counters. It answers host reads and writes by address, and can stream all counters out in sequence on a single dump request.

## Interface
- `NUM_CNTR`, 3, number of counters and probe channels (≥1)
- `NDIR`, 2, address width; must satisfy 2^NDIR ≥ NUM_CNTR
- `PROBE_W`, 8, bits per probe channel (1..16)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `habilitar`  in  1  counting enable
- `sondas`  in  NUM_CNTR*PROBE_W  probe buses; channel i = bits [i*PROBE_W +: PROBE_W]
- `dir`  in  NDIR  host address
- `LE`  in  1  1 = read request, 0 = write phase
- `wr`  in  1  write strobe, honoured only when LE=0
- `dato_in`  in  32  write data
- `volcar`  in  1  one-cycle dump request
- `dato_out`  out  32  read/dump data, registered
- `dato_valido`  out  1  dato_out valid this cycle
- `ultimo`  out  1  marks last dump word
- `ocupado`  out  1  dump in progress

## Operation
- Reset: all counters 0, probe history 0, `primado`=0, FSM=IDLE, `dato_out`=0, `dato_valido`=0, `ultimo`=0, `ocupado`=0.
- Counting, per channel i, at each edge with `habilitar`=1:
  - If `primado`=0: capture `sondas` into history only, with no count; set `primado`=1.
  - Else: cnt[i] ← min(cnt[i] + popcount(sonda_i XOR hist_i), 32'hFFFFFFFF); history ← sondas.
- With `habilitar`=0, counters and history hold. `primado` is kept, so toggles that occur while disabled are counted once at re-enable.
- Host write (LE=0, wr=1, dir<NUM_CNTR): cnt[dir] ← dato_in. The write wins over that channel's same-cycle increment; other channels count normally. Writes with dir ≥ NUM_CNTR are ignored. Writes are accepted in any FSM state.
- Host read (LE=1, FSM=IDLE, no `volcar`): next cycle `dato_out`=cnt[dir] (pre-update value) and `dato_valido`=1. If dir ≥ NUM_CNTR, `dato_out`=0 and `dato_valido`=1.
- FSM:
  - IDLE → DUMP on `volcar`=1. Dump index is cleared to 0 and `ocupado`=1 from the next cycle.
  - DUMP: each cycle `dato_out`=cnt[idx] (live value), `dato_valido`=1, `ultimo`=(idx==NUM_CNTR-1), idx++.
  - DUMP → IDLE after the last word is issued; `ocupado` drops the cycle after `ultimo`.
- Conflicts:
  - `volcar` and a read in the same IDLE cycle: the dump wins and the read is dropped.
  - `volcar` or reads while `ocupado`: ignored.
  - Reset mid-dump: immediate return to IDLE with all outputs at their reset values.

## Timing
- Counter update latency: a probe change present before edge k is counted at edge k (once primed) and is readable with a read issued in cycle k+1.
- Read latency is 1 cycle; back-to-back reads are allowed, one per cycle.
- Dump takes NUM_CNTR consecutive valid cycles starting 1 cycle after `volcar`. The next `volcar` is accepted in the cycle `ocupado` is 0.
- `dato_valido` is a one-cycle pulse per word; there is no backpressure.

## Structure
- Shared package `pwr_cntr_pkg`: counter width constant (32), saturation value, and the FSM state enum (IDLE, DUMP).
- Sub-module `popcount_sat_add`: PROBE_W-bit XOR popcount plus 32-bit saturating add, instantiated once per channel.
- The top level holds the counter array, history register, host port decode and the FSM.

## Test plan
- Reset, habilitar=1, channel 0 steps 00→FF→00 over 3 cycles → the first cycle primes only; read dir=0 returns 16; other channels read 0.
- Write cnt[1]=32'hFFFFFFF0 while channel 1 toggles 0x00↔0xFF every cycle → reads saturate at 32'hFFFFFFFF and stay there.
- Write dir=2, dato_in=5, in the same cycle as a channel-2 toggle of 3 bits → read returns 5, not 8; channel 0 still increments.
- Read dir=3 with NUM_CNTR=3 → dato_out=0, dato_valido=1; write to dir=3 → no counter changes.
- Counters preloaded 7/8/9, then `volcar` → 3 consecutive valid words 7, 8, 9; ultimo only on 9; ocupado high 3 cycles; a read and a second `volcar` during the dump are ignored.
- Assert reset on the second dump cycle → the next cycle shows ocupado=0, dato_valido=0, all counters 0; a subsequent dump outputs 0, 0, 0.
